serial_subtractor_n: RTL and testbench
======================================

# serial_subtractor_n

Parametrised, multi-cycle ripple-borrow subtractor computing A − B − Cin over WIDTH bits, processing DIGIT bits per clock with a registered borrow between slices. It is the sequenced successor of the combinational 4-bit subtractor in the ALU datapath. It trades latency for a single narrow borrow slice and sits behind the ALU operand registers with a valid/ready handshake on both sides.

## Interface
- WIDTH, 8: operand and result width in bits; ≥2.
- DIGIT, 1: bits subtracted per clock. WIDTH mod DIGIT must be 0; elaboration fails otherwise.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- A  in  WIDTH  minuend
- B  in  WIDTH  subtrahend
- Cin  in  1  borrow-in
- out_valid  out  1  result held on S/Cout/Ovf
- out_ready  in  1  consumer takes result
- S  out  WIDTH  difference, A − B − Cin mod 2^WIDTH
- Cout  out  1  borrow-out: 1 iff A < B + Cin (unsigned)
- Ovf  out  1  signed (two's complement) overflow; see Configuration

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n). rst_n low forces IDLE, in_ready=1, out_valid=0, S=0, Cout=0, Ovf=0, slice counter=0, at any time including mid-RUN; the in-flight operation is discarded.
- N = WIDTH/DIGIT slices. FSM states:
  - IDLE: in_ready=1. On in_valid=1, capture A, B and Cin into internal registers, clear S, counter=0, and go to RUN. Otherwise stay.
  - RUN: in_ready=0. Each edge subtracts slice k (bits k·DIGIT+DIGIT−1 .. k·DIGIT) of A and B plus the registered borrow (Cin for k=0), writes the difference slice into S, registers the slice borrow-out, and increments k. On the edge processing k=N−1, latch the final borrow into Cout, compute Ovf, and go to DONE.
  - DONE: out_valid=1; S/Cout/Ovf held stable. On out_ready=1, go to IDLE, out_valid=0. Otherwise stay.
- Operands are sampled only at the accepting edge. A/B/Cin changes afterwards have no effect.
- in_valid is ignored outside IDLE, and in_ready=0 there, so no operand is ever lost silently.
- No new operation is accepted in the cycle a result is consumed. Minimum issue interval is N+2 cycles.
- The arithmetic result is bit-identical to a WIDTH-bit combinational ripple subtractor for all inputs.

## Timing
- Accept edge E0 (in_valid & in_ready). RUN edges E1..EN. out_valid rises after EN. Latency is N cycles, accept to out_valid.
- DIGIT=WIDTH gives N=1: one RUN edge, result one cycle after accept.
- S shows partial results during RUN. It is valid only while out_valid=1.
- Consume edge: out_ready=1 while out_valid=1. in_ready rises the cycle after.
- All outputs are registered. There is no combinational input→output path.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined: Ovf = (A[WIDTH−1] ≠ B[WIDTH−1]) & (S[WIDTH−1] ≠ A[WIDTH−1]), using captured operands. It is registered with Cout on the final RUN edge. Cin is included in S.
- Not defined: the Ovf port exists but is tied to 0. No overflow logic or captured sign bits are synthesised.

## Test plan
- WIDTH=8, DIGIT=1: A=0x05, B=0x03, Cin=0 -> out_valid exactly 8 cycles after accept; S=0x02, Cout=0, Ovf=0.
- WIDTH=8, DIGIT=1: A=0x00, B=0x01, Cin=0 -> S=0xFF, Cout=1, Ovf=0. A=0x05, B=0x05, Cin=1 -> S=0xFF, Cout=1.
- WIDTH=8, DIGIT=4, macro defined: A=0x80, B=0x01, Cin=0 -> after 2 cycles S=0x7F, Cout=0, Ovf=1. Without macro -> Ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> S/Cout stay stable. Pulse in_valid with new operands while in DONE -> ignored, in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: drop rst_n asynchronously at k=3 -> outputs immediately 0, in_ready=1. Release, then A=0x10, B=0x01 -> S=0x0F, Cout=0 with normal latency.
- Randomised: 1000 vectors at WIDTH=16, DIGIT ∈ {1,2,4,8,16} against the reference model {Cout,S} = A − B − Cin -> zero mismatches.

Source files
------------

// File: rtl/serial_subtractor_n.sv
// serial_subtractor_n: multi-cycle ripple-borrow subtractor, S = A - B - Cin, DIGIT bits per clock
// Ports: clk, rst_n (async active-low); in_valid/in_ready accept A, B, Cin;
//        out_valid/out_ready hand off S (difference), Cout (unsigned borrow-out), Ovf (signed overflow).
// Define SERIAL_SUB_OVERFLOW_EN to build the overflow flag; otherwise Ovf is tied to 0.
module serial_subtractor_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_subtractor_n: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate
  logic [1:0] state;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] a_r, b_r;
  logic br;
  logic [DIGIT:0] diff;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic last;
  // Operands shift right so the current slice is always the low DIGIT bits;
  // the top bit of the (DIGIT+1)-bit difference is the slice borrow-out.
  assign diff = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, br};
  // Difference slices enter S from the top, landing in place after N steps.
  assign s_cat = {diff[DIGIT-1:0], S};
  assign last = k == KW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      a_r <= '0;
      b_r <= '0;
      br <= 1'b0;
      S <= '0;
      Cout <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_r <= A;
        b_r <= B;
        br <= Cin;
        S <= '0;
        k <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_r <= a_r >> DIGIT;
      b_r <= b_r >> DIGIT;
      br <= diff[DIGIT];
      S <= s_cat[WIDTH+DIGIT-1:DIGIT];
      k <= k + 1'b1;
      if (last) begin
        Cout <= diff[DIGIT];
        state <= DONE;
      end
    end else if (state == DONE) begin
      if (out_ready) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic sa, sb;
  // Differing operand signs plus a result sign that departs from A's means overflow;
  // the result sign is the top bit of the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa <= 1'b0;
      sb <= 1'b0;
      Ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sa <= A[WIDTH-1];
      sb <= B[WIDTH-1];
    end else if (state == RUN && last) begin
      Ovf <= (sa ^ sb) & (diff[DIGIT-1] ^ sa);
    end
  end
`else
  assign Ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor_n.sv
// tb_serial_subtractor_n: directed and randomised checks of serial_subtractor_n against an arithmetic model
module tb_serial_subtractor_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int sgn(input int v, input int w);
    return v >= (1 << (w - 1)) ? v - (1 << w) : v;
  endfunction
  function automatic logic [31:0] ovf_exp(input int a, input int b, input int c, input int w);
`ifdef SERIAL_SUB_OVERFLOW_EN
    int d;
    d = sgn(a, w) - sgn(b, w) - c;
    return (d < -(1 << (w - 1)) || d > (1 << (w - 1)) - 1) ? 32'd1 : 32'd0;
`else
    return 32'd0;
`endif
  endfunction
  logic dv, dr, dc;
  logic [7:0] da, db;
  logic d1_ir, d1_ov, d1_co, d1_of, d4_ir, d4_ov, d4_co, d4_of;
  logic [7:0] d1_s, d4_s;
  serial_subtractor_n #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(dv), .in_ready(d1_ir), .A(da), .B(db), .Cin(dc),
    .out_valid(d1_ov), .out_ready(dr), .S(d1_s), .Cout(d1_co), .Ovf(d1_of)
  );
  serial_subtractor_n #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(dv), .in_ready(d4_ir), .A(da), .B(db), .Cin(dc),
    .out_valid(d4_ov), .out_ready(dr), .S(d4_s), .Cout(d4_co), .Ovf(d4_of)
  );
  logic rv, rr, rc;
  logic [15:0] ra, rb;
  logic [4:0] rir, rov, rco, rof;
  logic [15:0] rs [5];
  for (genvar g = 0; g < 5; g++) begin : g_r
    serial_subtractor_n #(.WIDTH(16), .DIGIT(1 << g)) u_r (
      .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(rir[g]), .A(ra), .B(rb), .Cin(rc),
      .out_valid(rov[g]), .out_ready(rr), .S(rs[g]), .Cout(rco[g]), .Ovf(rof[g])
    );
  end
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit consume);
    int l1, l4, d;
    l1 = -1;
    l4 = -1;
    chk("d_in_ready", {d4_ir, d1_ir}, 32'h3);
    da = a;
    db = b;
    dc = c;
    dv = 1'b1;
    tick;
    dv = 1'b0;
    da = ~a;
    db = ~b;
    dc = ~c;
    for (int i = 1; i <= 20 && (l1 < 0 || l4 < 0); i++) begin
      tick;
      if (d1_ov && l1 < 0) l1 = i;
      if (d4_ov && l4 < 0) l4 = i;
    end
    d = int'(a) - int'(b) - int'(c);
    chk("d1_latency", l1, 32'd8);
    chk("d4_latency", l4, 32'd2);
    chk("d1_s", d1_s, d & 255);
    chk("d4_s", d4_s, d & 255);
    chk("d1_cout", d1_co, d < 0);
    chk("d4_cout", d4_co, d < 0);
    chk("d1_ovf", d1_of, ovf_exp(a, b, c, 8));
    chk("d4_ovf", d4_of, ovf_exp(a, b, c, 8));
    if (consume) begin
      dr = 1'b1;
      tick;
      dr = 1'b0;
    end
  endtask
  initial begin
    int lat [5];
    int d;
    dv = 0; dr = 0; dc = 0; da = 0; db = 0;
    rv = 0; rr = 0; rc = 0; ra = 0; rb = 0;
    tick;
    tick;
    chk("rst_in_ready", d1_ir, 1);
    chk("rst_out_valid", d1_ov, 0);
    chk("rst_s", d1_s, 0);
    chk("rst_cout", d1_co, 0);
    chk("rst_ovf", d1_of, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    run8(8'h05, 8'h03, 1'b0, 1);
    run8(8'h00, 8'h01, 1'b0, 1);
    run8(8'h05, 8'h05, 1'b1, 1);
    run8(8'h80, 8'h01, 1'b0, 1);
    // backpressure: hold result, then try to push new operands while in DONE
    run8(8'h3c, 8'h5a, 1'b1, 0);
    d = 8'h3c - 8'h5a - 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", d1_ov, 1);
      chk("bp_s", d1_s, d & 255);
      chk("bp_cout", d1_co, d < 0);
    end
    da = 8'h77; db = 8'h11; dc = 0; dv = 1'b1;
    chk("bp_in_ready", d1_ir, 0);
    tick;
    dv = 1'b0;
    chk("bp_ignored_s", d1_s, d & 255);
    chk("bp_ignored_valid", d1_ov, 1);
    dr = 1'b1;
    tick;
    dr = 1'b0;
    chk("bp_consumed_valid", d1_ov, 0);
    chk("bp_consumed_ready", d1_ir, 1);
    // asynchronous reset in the middle of a run
    da = 8'hc3; db = 8'h3c; dc = 1; dv = 1'b1;
    tick;
    dv = 1'b0;
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", d1_ir, 1);
    chk("arst_out_valid", d1_ov, 0);
    chk("arst_s", d1_s, 0);
    chk("arst_cout", d1_co, 0);
    chk("arst_ovf", d1_of, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    run8(8'h10, 8'h01, 1'b0, 1);
    for (int v = 0; v < 1000; v++) begin
      ra = v == 0 ? 16'h0000 : v == 1 ? 16'h0000 : v == 2 ? 16'h8000 : v == 3 ? 16'h7fff : 16'($urandom);
      rb = v == 0 ? 16'h0000 : v == 1 ? 16'hffff : v == 2 ? 16'h0001 : v == 3 ? 16'hffff : 16'($urandom);
      rc = v < 4 ? v[0] : 1'($urandom_range(0, 1));
      chk("r_in_ready", rir, 32'h1f);
      rv = 1'b1;
      tick;
      rv = 1'b0;
      d = int'(ra) - int'(rb) - int'(rc);
      for (int g = 0; g < 5; g++) lat[g] = -1;
      for (int i = 1; i <= 20; i++) begin
        tick;
        for (int g = 0; g < 5; g++) if (rov[g] && lat[g] < 0) lat[g] = i;
      end
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("r_lat_d%0d", 1 << g), lat[g], 16 >> g);
        chk($sformatf("r_s_d%0d", 1 << g), rs[g], d & 16'hffff);
        chk($sformatf("r_cout_d%0d", 1 << g), rco[g], d < 0);
        chk($sformatf("r_ovf_d%0d", 1 << g), rof[g], ovf_exp(ra, rb, rc, 16));
      end
      rr = 1'b1;
      tick;
      rr = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
